// File: rtl/cnn_eval_if.sv
// Bus between the evaluation sequencer and its environment: pixel/label RAM
// read ports, the chip's serial pixel/decision pins, run control and scoreboard.
interface cnn_eval_if #(
   parameter int PIX_W   = 8,
   parameter int IDX_W   = 10,
   parameter int ADDR_W  = 20,
   parameter int CLASS_W = 4
);
   logic               start;
   logic               mode_rand;
   logic [ADDR_W-1:0]  pix_addr;
   logic [PIX_W-1:0]   pix_rdata;
   logic [IDX_W-1:0]   lbl_addr;
   logic [CLASS_W-1:0] lbl_rdata;
   logic               dut_rst_n;
   logic [PIX_W-1:0]   dut_data;
   logic [CLASS_W-1:0] dut_decision;
   logic               dut_valid;
   logic               busy;
   logic               done;
   logic               res_valid;
   logic               res_hit;
   logic [IDX_W-1:0]   res_idx;
   logic [IDX_W:0]     img_cnt;
   logic [IDX_W:0]     hit_cnt;
   logic [IDX_W:0]     to_cnt;

   modport master (
      input  start, mode_rand, pix_rdata, lbl_rdata, dut_decision, dut_valid,
      output pix_addr, lbl_addr, dut_rst_n, dut_data, busy, done,
             res_valid, res_hit, res_idx, img_cnt, hit_cnt, to_cnt
   );

   modport slave (
      output start, mode_rand, pix_rdata, lbl_rdata, dut_decision, dut_valid,
      input  pix_addr, lbl_addr, dut_rst_n, dut_data, busy, done,
             res_valid, res_hit, res_idx, img_cnt, hit_cnt, to_cnt
   );
endinterface

// File: rtl/cnn_eval_sequencer.sv
// Evaluation sequencer: per image, pulses chip reset, streams pixels from RAM,
// waits for the chip decision (with timeout) and scores it against the label RAM.
module cnn_eval_sequencer #(
   parameter int          PIX_W      = 8,
   parameter int          IMG_PIXELS = 784,
   parameter int          NUM_IMG    = 1000,
   parameter int          IDX_W      = 10,
   parameter int          ADDR_W     = 20,
   parameter int          CLASS_W    = 4,
   parameter int          RST_CYC    = 2,
   parameter int          TIMEOUT    = 4096,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   cnn_eval_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_PICK, S_DRST, S_STREAM, S_WAIT, S_SCORE, S_DONE
   } state_e;

   localparam int P_W   = $clog2(IMG_PIXELS + 2);
   localparam int W_W   = $clog2(TIMEOUT + 1);
   localparam int C_W   = $clog2(RST_CYC + 1);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] NUM_IMG_C = CNT_W'(NUM_IMG);

   state_e             state_q, state_d;
   logic               mode_q, mode_d;
   logic [15:0]        lfsr_q, lfsr_d, lfsr_nxt;
   logic [IDX_W-1:0]   sel_q, sel_d, sel_c;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [C_W-1:0]     cyc_q, cyc_d;
   logic [P_W-1:0]     pix_q, pix_d;
   logic [W_W-1:0]     wcnt_q, wcnt_d;
   logic [CLASS_W-1:0] label_q, label_d, dec_q, dec_d;
   logic               tmo_q, tmo_d;
   logic [PIX_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   img_q, img_d, hit_q, hit_d, to_q, to_d;
   logic               pick_ok, hit_c;

   assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign sel_c    = mode_q ? lfsr_nxt[IDX_W-1:0] : img_q[IDX_W-1:0];
   // Random mode rejects LFSR draws that fall outside the image set
   assign pick_ok  = !mode_q || ({1'b0, lfsr_nxt[IDX_W-1:0]} < NUM_IMG_C);
   assign hit_c    = (dec_q == label_q) && !tmo_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      lfsr_d  = lfsr_q;
      sel_d   = sel_q;
      base_d  = base_q;
      cyc_d   = cyc_q;
      pix_d   = pix_q;
      wcnt_d  = wcnt_q;
      label_d = label_q;
      dec_d   = dec_q;
      tmo_d   = tmo_q;
      data_d  = data_q;
      img_d   = img_q;
      hit_d   = hit_q;
      to_d    = to_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               img_d   = '0;
               hit_d   = '0;
               to_d    = '0;
               mode_d  = bus.mode_rand;
               state_d = S_PICK;
            end
         end
         S_PICK: begin
            if (mode_q) lfsr_d = lfsr_nxt;
            if (pick_ok) begin
               sel_d   = sel_c;
               base_d  = ADDR_W'(sel_c) * ADDR_W'(IMG_PIXELS);
               cyc_d   = '0;
               state_d = S_DRST;
            end
         end
         S_DRST: begin
            // lbl_addr was presented in PICK, so the label is on lbl_rdata now
            if (cyc_q == '0) label_d = bus.lbl_rdata;
            if (cyc_q == C_W'(RST_CYC - 1)) begin
               pix_d   = '0;
               state_d = S_STREAM;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (pix_q != '0 && pix_q <= P_W'(IMG_PIXELS)) data_d = bus.pix_rdata;
            if (pix_q == P_W'(IMG_PIXELS + 1)) begin
               wcnt_d  = '0;
               state_d = S_WAIT;
            end else begin
               pix_d = pix_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.dut_valid) begin
               dec_d   = bus.dut_decision;
               tmo_d   = 1'b0;
               state_d = S_SCORE;
            end else if (wcnt_q == W_W'(TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               state_d = S_SCORE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_SCORE: begin
            img_d   = img_q + 1'b1;
            hit_d   = hit_q + CNT_W'(hit_c);
            to_d    = to_q + CNT_W'(tmo_q);
            state_d = (img_q == NUM_IMG_C - 1'b1) ? S_DONE : S_PICK;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         sel_q   <= '0;
         base_q  <= '0;
         cyc_q   <= '0;
         pix_q   <= '0;
         wcnt_q  <= '0;
         label_q <= '0;
         dec_q   <= '0;
         tmo_q   <= 1'b0;
         data_q  <= '0;
         img_q   <= '0;
         hit_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         lfsr_q  <= lfsr_d;
         sel_q   <= sel_d;
         base_q  <= base_d;
         cyc_q   <= cyc_d;
         pix_q   <= pix_d;
         wcnt_q  <= wcnt_d;
         label_q <= label_d;
         dec_q   <= dec_d;
         tmo_q   <= tmo_d;
         data_q  <= data_d;
         img_q   <= img_d;
         hit_q   <= hit_d;
         to_q    <= to_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.res_valid = (state_q == S_SCORE);
   assign bus.res_hit   = (state_q == S_SCORE) && hit_c;
   assign bus.res_idx   = sel_q;
   assign bus.lbl_addr  = (state_q == S_PICK) ? sel_c : sel_q;
   assign bus.pix_addr  = (state_q == S_STREAM && pix_q < P_W'(IMG_PIXELS)) ?
                          base_q + ADDR_W'(pix_q) : '0;
   assign bus.dut_rst_n = (state_q == S_STREAM) || (state_q == S_WAIT) ||
                          (state_q == S_SCORE);
   assign bus.dut_data  = data_q;
   assign bus.img_cnt   = img_q;
   assign bus.hit_cnt   = hit_q;
   assign bus.to_cnt    = to_q;
endmodule

// File: tb/tb_cnn_eval_sequencer.sv
// Bench for cnn_eval_sequencer: a small 3-image instance with a scripted chip
// model, and a 1000-image instance scored against a golden match count.
module tb_cnn_eval_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_eval_if #(.PIX_W(8), .IDX_W(2),  .ADDR_W(8),  .CLASS_W(4)) ba ();
  cnn_eval_if #(.PIX_W(8), .IDX_W(10), .ADDR_W(12), .CLASS_W(4)) bb ();

  cnn_eval_sequencer #(.PIX_W(8), .IMG_PIXELS(4), .NUM_IMG(3), .IDX_W(2), .ADDR_W(8),
    .CLASS_W(4), .RST_CYC(2), .TIMEOUT(16), .LFSR_SEED(16'hACE1))
    dut_a (.clk(clk), .rst(rst), .bus(ba));

  cnn_eval_sequencer #(.PIX_W(8), .IMG_PIXELS(4), .NUM_IMG(1000), .IDX_W(10), .ADDR_W(12),
    .CLASS_W(4), .RST_CYC(2), .TIMEOUT(16), .LFSR_SEED(16'hACE1))
    dut_b (.clk(clk), .rst(rst), .bus(bb));

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instance A: memories + chip model ----------------
  logic [7:0] pix_a [256];
  logic [3:0] lbl_a [4];
  always @(posedge clk) begin
    ba.pix_rdata <= pix_a[ba.pix_addr];
    ba.lbl_rdata <= lbl_a[ba.lbl_addr];
  end

  logic [2:0][3:0] dec_tbl = '0;
  logic [2:0] mute = '0;
  logic spur = 1'b0;
  int ca = 0, cur_a = 0, done_a = 0;
  int res_idx_q[$], res_hit_q[$], res_c_q[$], strm_q[$];

  always @(posedge clk) ca <= ba.dut_rst_n ? ca + 1 : 0;
  assign ba.dut_valid = ba.dut_rst_n && ((ca == 10 && !mute[cur_a]) || (spur && ca == 1));
  assign ba.dut_decision = dec_tbl[cur_a];

  always @(negedge clk) begin
    if (ba.dut_rst_n && ca >= 2 && ca <= 5) begin
      strm_q.push_back(int'(ba.dut_data));
      if (ca == 2) cur_a <= int'(ba.dut_data) / 4;
    end
    if (ba.res_valid) begin
      res_idx_q.push_back(int'(ba.res_idx));
      res_hit_q.push_back(int'(ba.res_hit));
      res_c_q.push_back(ca);
    end
    if (ba.done) done_a <= done_a + 1;
  end

  // ---------------- instance B: memories + chip model ----------------
  logic [7:0] pix_b [4096];
  logic [3:0] lbl_b [1024];
  always @(posedge clk) begin
    bb.pix_rdata <= pix_b[bb.pix_addr];
    bb.lbl_rdata <= lbl_b[bb.lbl_addr];
  end

  int cb = 0, res_b = 0, done_b = 0;
  logic [7:0] sum_b = '0;
  always @(posedge clk) cb <= bb.dut_rst_n ? cb + 1 : 0;
  // chip B decides sum-of-pixels mod 16
  assign bb.dut_valid = bb.dut_rst_n && cb == 7;
  assign bb.dut_decision = sum_b[3:0];
  always @(negedge clk) begin
    if (bb.dut_rst_n && cb >= 2 && cb <= 5) sum_b <= (cb == 2) ? bb.dut_data : sum_b + bb.dut_data;
    if (bb.res_valid) res_b <= res_b + 1;
    if (bb.done) done_b <= done_b + 1;
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic run_a(input logic m, input int maxc, output int cyc);
    @(negedge clk);
    ba.start = 1'b1;
    ba.mode_rand = m;
    @(negedge clk);
    ba.start = 1'b0;
    chk("busy after start", ba.busy, 1);
    cyc = 1;
    while (ba.done !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= maxc) chk("run A timed out", cyc, 0);
  endtask

  typedef struct {
    logic [2:0][3:0] dec;
    logic [2:0]      mute;
    logic            spur;
    int              exp_hit;
    int              exp_to;
    logic [2:0]      exp_hits;
    int              exp_cyc;
  } vec_t;

  vec_t tv [3];
  int cyc, n0, s0, d0, g, t;
  int exp_idx [3];
  logic [15:0] lf;
  logic [7:0] s8;

  initial begin
    ba.start = 1'b0; ba.mode_rand = 1'b0;
    bb.start = 1'b0; bb.mode_rand = 1'b0;
    // decisions stored {img2, img1, img0}
    tv[0] = '{dec: {4'd3, 4'd2, 4'd1}, mute: 3'b000, spur: 1'b0, exp_hit: 3, exp_to: 0, exp_hits: 3'b111, exp_cyc: 46};
    tv[1] = '{dec: {4'd3, 4'd5, 4'd1}, mute: 3'b000, spur: 1'b1, exp_hit: 2, exp_to: 0, exp_hits: 3'b101, exp_cyc: 46};
    tv[2] = '{dec: {4'd3, 4'd2, 4'd1}, mute: 3'b010, spur: 1'b0, exp_hit: 2, exp_to: 1, exp_hits: 3'b101, exp_cyc: 57};

    for (int a = 0; a < 256; a++) pix_a[a] = 8'(a);
    lbl_a[0] = 4'd1; lbl_a[1] = 4'd2; lbl_a[2] = 4'd3; lbl_a[3] = 4'd0;
    g = 0;
    for (int i = 0; i < 1024; i++) lbl_b[i] = 4'($urandom_range(0, 15));
    for (int a = 0; a < 4096; a++) pix_b[a] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1000; i++) begin
      s8 = pix_b[4*i] + pix_b[4*i+1] + pix_b[4*i+2] + pix_b[4*i+3];
      if (i % 3 != 2) lbl_b[i] = s8[3:0];
      if (lbl_b[i] == s8[3:0]) g++;
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy", ba.busy, 0);
    chk("rst done", ba.done, 0);
    chk("rst dut_rst_n", ba.dut_rst_n, 0);
    chk("rst res_valid", ba.res_valid, 0);
    chk("rst img_cnt", ba.img_cnt, 0);
    chk("rst pix_addr", ba.pix_addr, 0);
    chk("rst dut_data", ba.dut_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // sequential runs: scoring, mismatches, timeout
    for (int v = 0; v < 3; v++) begin
      dec_tbl = tv[v].dec; mute = tv[v].mute; spur = tv[v].spur;
      n0 = res_idx_q.size(); s0 = strm_q.size(); d0 = done_a;
      run_a(1'b0, 200, cyc);
      chk($sformatf("v%0d run cycles", v), cyc, tv[v].exp_cyc);
      chk($sformatf("v%0d busy at done", v), ba.busy, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d done pulses", v), done_a - d0, 1);
      chk($sformatf("v%0d img_cnt", v), ba.img_cnt, 3);
      chk($sformatf("v%0d hit_cnt", v), ba.hit_cnt, tv[v].exp_hit);
      chk($sformatf("v%0d to_cnt", v), ba.to_cnt, tv[v].exp_to);
      chk($sformatf("v%0d results", v), res_idx_q.size() - n0, 3);
      for (int i = 0; i < 3; i++) if (n0 + i < res_idx_q.size()) begin
        chk($sformatf("v%0d res_idx[%0d]", v, i), res_idx_q[n0+i], i);
        chk($sformatf("v%0d res_hit[%0d]", v, i), res_hit_q[n0+i], tv[v].exp_hits[i]);
        chk($sformatf("v%0d score cyc[%0d]", v, i), res_c_q[n0+i], tv[v].mute[i] ? 22 : 11);
      end
      if (v == 0) begin
        chk("stream length", strm_q.size() - s0, 12);
        for (int k = 0; k < 12; k++)
          if (s0 + k < strm_q.size()) chk($sformatf("dut_data[%0d]", k), strm_q[s0+k], k);
      end
    end

    // random order from the seed
    lf = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      lf = lstep(lf);
      while (lf[1:0] == 2'd3) lf = lstep(lf);
      exp_idx[i] = int'(lf[1:0]);
    end
    dec_tbl = tv[0].dec; mute = '0; spur = 1'b0;
    n0 = res_idx_q.size();
    run_a(1'b1, 400, cyc);
    repeat (2) @(negedge clk);
    chk("rand img_cnt", ba.img_cnt, 3);
    chk("rand hit_cnt", ba.hit_cnt, 3);
    chk("rand results", res_idx_q.size() - n0, 3);
    for (int i = 0; i < 3; i++) if (n0 + i < res_idx_q.size())
      chk($sformatf("rand res_idx[%0d]", i), res_idx_q[n0+i], exp_idx[i]);

    // reset mid-STREAM of the second image, then a clean rerun from the seed
    n0 = res_idx_q.size();
    @(negedge clk);
    ba.start = 1'b1; ba.mode_rand = 1'b1;
    @(negedge clk);
    ba.start = 1'b0;
    t = 0;
    while (!(res_idx_q.size() > n0 && ba.dut_rst_n && ca == 3) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("reached 2nd stream", t < 300, 1);
    chk("img_cnt before rst", ba.img_cnt, 1);
    rst = 1'b1;
    d0 = done_a;
    @(negedge clk);
    chk("mid rst busy", ba.busy, 0);
    chk("mid rst dut_rst_n", ba.dut_rst_n, 0);
    chk("mid rst img_cnt", ba.img_cnt, 0);
    chk("mid rst hit_cnt", ba.hit_cnt, 0);
    rst = 1'b0;
    n0 = res_idx_q.size();
    repeat (40) @(negedge clk);
    chk("no done after rst", done_a - d0, 0);
    chk("no result after rst", res_idx_q.size() - n0, 0);
    run_a(1'b1, 400, cyc);
    repeat (2) @(negedge clk);
    chk("rerun img_cnt", ba.img_cnt, 3);
    chk("rerun hit_cnt", ba.hit_cnt, 3);
    chk("rerun done", done_a - d0, 1);
    for (int i = 0; i < 3; i++) if (n0 + i < res_idx_q.size())
      chk($sformatf("rerun res_idx[%0d]", i), res_idx_q[n0+i], exp_idx[i]);

    // 1000-image sequential run
    @(negedge clk);
    bb.start = 1'b1; bb.mode_rand = 1'b0;
    @(negedge clk);
    bb.start = 1'b0;
    cyc = 1;
    while (bb.done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("B run cycles", cyc, 12001);
    repeat (2) @(negedge clk);
    chk("B img_cnt", bb.img_cnt, 1000);
    chk("B hit_cnt", bb.hit_cnt, g);
    chk("B to_cnt", bb.to_cnt, 0);
    chk("B results", res_b, 1000);
    chk("B done pulses", done_b, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cnn_eval_sequencer.md
Name: cnn_eval_sequencer

Overview:
- Synthesizable evaluation sequencer for the CNN chip: streams NUM_IMG images of IMG_PIXELS pixels from an external pixel RAM into the chip's serial pixel input.
- Pulses the chip reset before every image, waits for its decision and scores it against a label RAM.
- Accumulates hit, miss and timeout counts; supports sequential or LFSR-randomised image order.
- Sits between the on-board pixel/label memories and chip; replaces bench-side stimulus/scoring loops in FPGA bring-up.

Parameters:
PIX_W, 8, pixel width
IMG_PIXELS, 784, pixels per image
NUM_IMG, 1000, images per run (>=1)
IDX_W, 10, image index width (2^IDX_W >= NUM_IMG)
ADDR_W, 20, pixel address width (>= log2(NUM_IMG*IMG_PIXELS))
CLASS_W, 4, decision/label width
RST_CYC, 2, chip reset low cycles per image (>=1)
TIMEOUT, 4096, max WAIT cycles for dut_valid
LFSR_SEED, 16'hACE1, nonzero random-mode seed

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  1-cycle run request, sampled only in IDLE
mode_rand  in  1  0 sequential order, 1 LFSR order; latched at start
pix_addr  out  ADDR_W  pixel RAM read address
pix_rdata  in  PIX_W  pixel RAM data, valid 1 cycle after pix_addr
lbl_addr  out  IDX_W  label RAM address
lbl_rdata  in  CLASS_W  label data, valid 1 cycle after lbl_addr
dut_rst_n  out  1  chip reset, active low
dut_data  out  PIX_W  chip pixel input
dut_decision  in  CLASS_W  chip decision
dut_valid  in  1  chip decision strobe
busy  out  1  high from start acceptance until DONE
done  out  1  1-cycle pulse at run end
res_valid  out  1  1-cycle pulse per scored image
res_hit  out  1  qualifies res_valid
res_idx  out  IDX_W  image index of scored result
img_cnt  out  IDX_W+1  images scored this run
hit_cnt  out  IDX_W+1  correct decisions
to_cnt  out  IDX_W+1  timeouts

Behaviour:
- Reset: state IDLE; all outputs 0 except dut_rst_n=0 (chip held in reset); LFSR=LFSR_SEED; counters 0.
- States: IDLE, PICK, DRST, STREAM, WAIT, SCORE, DONE.
- IDLE: start=1 -> clear img_cnt/hit_cnt/to_cnt, latch mode_rand, busy=1, -> PICK. start in other states ignored.
- PICK: sequential: img_sel=img_cnt, 1 cycle. Random: advance LFSR (x^16+x^14+x^13+x^11) each cycle; leave when LFSR[IDX_W-1:0] < NUM_IMG, img_sel = those bits. Register base = img_sel*IMG_PIXELS (one registered multiply). Drive lbl_addr=img_sel. -> DRST.
- DRST: dut_rst_n=0 for exactly RST_CYC cycles; label captured from lbl_rdata on the first DRST cycle. -> STREAM.
- STREAM: IMG_PIXELS cycles, pix_addr=base+p, p=0..IMG_PIXELS-1. dut_data<=pix_rdata registered, so pixel p reaches dut_data 2 cycles after its address. dut_rst_n=1 from STREAM entry. After last address plus 2 flush cycles -> WAIT. dut_valid during PICK/DRST/STREAM ignored.
- WAIT: wait counter from 0. dut_valid=1 -> capture dut_decision, -> SCORE. Counter reaches TIMEOUT-1 without dut_valid -> timeout, -> SCORE. dut_valid on the timeout cycle counts as a decision, not a timeout.
- SCORE, 1 cycle: res_valid=1, res_idx=img_sel, res_hit=(decision==label) and not timeout. img_cnt++, hit_cnt+=res_hit, to_cnt+=timeout. If img_cnt+1==NUM_IMG -> DONE else -> PICK. Random mode may repeat indices.
- DONE, 1 cycle: done=1, busy=0, dut_rst_n=0, -> IDLE. Counters hold until next start.
- dut_data holds last value outside STREAM.
- rst mid-run: immediate return to reset values next edge; no res_valid/done emitted; LFSR reseeded.
- Counters never wrap; width IDX_W+1 covers NUM_IMG.

Test Plan:
Params IMG_PIXELS=4, NUM_IMG=3, RST_CYC=2, TIMEOUT=16 for 1–5.
1. Sequential run; RAM pixel[a]=a; chip model asserts valid 5 cycles after last pixel with decision=label -> dut_data sequence 0,1,2,3 / 4..7 / 8..11; 3 res_valid, hit_cnt=3, img_cnt=3, done 1 pulse.
2. Labels {1,2,3}, model returns {1,5,3} -> res_hit 1,0,1; hit_cnt=2, to_cnt=0.
3. Image 1 model never asserts valid -> SCORE after 16 WAIT cycles, res_hit=0, to_cnt=1, run still completes with img_cnt=3.
4. mode_rand=1, NUM_IMG=3, IDX_W=2 -> every res_idx in {0,1,2}; sequence matches reference LFSR with rejection from seed 16'hACE1.
5. rst pulsed mid-STREAM of image 1 -> next cycle busy=0, dut_rst_n=0, counters 0, no done; new start runs cleanly.
6. Default params, 1000-image sequential run with golden labels -> img_cnt=1000, hit_cnt equals golden model's match count.
